// File: rtl/cache_req_arbiter_if.sv
// Requester-side and cache-side signals of the shared cache port.
// master = requesters + cache environment, slave = the arbiter.
interface cache_req_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            ack;
  logic                          err;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          cache_re;
  logic                          cache_we;
  logic [ADDR_WIDTH-1:0]         cache_addr;
  logic [DATA_WIDTH-1:0]         cache_wdata;
  logic [DATA_WIDTH-1:0]         cache_rdata;
  logic                          cache_busy;
  logic                          cache_done;

  modport master (
    output req, req_we, req_addr, req_wdata, cache_rdata, cache_busy, cache_done,
    input  ack, err, rdata, cache_re, cache_we, cache_addr, cache_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, cache_rdata, cache_busy, cache_done,
    output ack, err, rdata, cache_re, cache_we, cache_addr, cache_wdata
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port; strobe one cycle after grant, ack the cycle after done.
// Requesters hold req until ack; no grant while the cache reports busy; one transaction in flight.
module cache_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst,
  cache_req_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   NREQ_C    = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_C    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        ptr, ptr_nxt;
  logic [PTR_W-1:0]        grant, grant_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    we_l, we_l_nxt;
  logic [NUM_REQ-1:0]      ack_q, ack_nxt;
  logic                    err_q, err_nxt;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
  logic                    re_q, re_nxt;
  logic                    we_q, we_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    found;
  logic [PTR_W-1:0]        pick;
  logic [PTR_W:0]          sum;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester at or after ptr, wrapping; sum never exceeds 2*NUM_REQ-2.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (sum >= NREQ_C) sum = sum - NREQ_C;
      if (!found && bus.req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    we_l_nxt  = we_l;
    ack_nxt   = '0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    re_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      ST_IDLE: begin
        if (found && !bus.cache_busy) begin
          grant_nxt = pick;
          we_l_nxt  = bus.req_we[pick];
          addr_nxt  = addr_arr[pick];
          wdata_nxt = wdata_arr[pick];
          re_nxt    = !bus.req_we[pick];
          we_nxt    = bus.req_we[pick];
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (bus.cache_done) begin
          ack_nxt[grant] = 1'b1;
          rdata_nxt      = we_l ? '0 : bus.cache_rdata;
          state_nxt      = ST_RESP;
        end else if (cnt == TIMEOUT_C) begin
          ack_nxt[grant] = 1'b1;
          err_nxt        = 1'b1;
          state_nxt      = ST_RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        ptr_nxt   = (grant == LAST_C) ? '0 : grant + PTR_W'(1);
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant   <= '0;
      cnt     <= '0;
      we_l    <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      grant   <= grant_nxt;
      cnt     <= cnt_nxt;
      we_l    <= we_l_nxt;
      ack_q   <= ack_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
      re_q    <= re_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.cache_re    = re_q;
  assign bus.cache_we    = we_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a small cache responder model (done after done_dly cycles).
module tb_cache_req_arbiter;
  localparam int NUM_REQ = 2;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // cache model controls
  int done_dly    = 2;
  bit no_done     = 1'b0;
  bit force_busy  = 1'b0;
  int stray_reqs  = 0;

  // monitor state
  int re_cnt = 0, we_cnt = 0, both_cnt = 0, ack_cnt = 0, onehot_bad = 0, unstable = 0;
  logic [7:0] s_addr = '0, s_wdata = '0;
  bit in_txn = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output logic [1:0] a, output logic e,
                          output logic [7:0] d, output int lat);
    a = '0; e = 1'b0; d = '0; lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack; e = bus.err; d = bus.rdata; lat = i;
        return;
      end
    end
  endtask

  // cache responder
  initial begin
    int left;
    bit pending;
    logic [7:0] p_addr;
    int fired;
    left = 0; pending = 1'b0; p_addr = '0; fired = 0;
    bus.cache_done = 1'b0; bus.cache_busy = 1'b0; bus.cache_rdata = 8'hC3;
    forever begin
      @(negedge clk);
      bus.cache_done  = 1'b0;
      bus.cache_rdata = 8'hC3;
      if (fired < stray_reqs) begin
        bus.cache_done = 1'b1;
        fired++;
      end
      if (pending) begin
        left--;
        if (left == 0) begin
          bus.cache_done  = 1'b1;
          bus.cache_rdata = ~p_addr;
          pending = 1'b0;
        end
      end
      if ((bus.cache_re || bus.cache_we) && !no_done) begin
        pending = 1'b1;
        left    = done_dly;
        p_addr  = bus.cache_addr;
      end
      bus.cache_busy = pending || force_busy;
    end
  end

  // strobe / ack monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) in_txn = 1'b0;
      if (bus.cache_re) re_cnt++;
      if (bus.cache_we) we_cnt++;
      if (bus.cache_re && bus.cache_we) both_cnt++;
      if (bus.cache_re || bus.cache_we) begin
        s_addr  = bus.cache_addr;
        s_wdata = bus.cache_wdata;
        in_txn  = 1'b1;
      end else if (in_txn && (bus.cache_addr != s_addr || bus.cache_wdata != s_wdata)) begin
        unstable++;
      end
      if (bus.ack != '0) begin
        ack_cnt++;
        if (!$onehot(bus.ack)) onehot_bad++;
        in_txn = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [1:0] a;
    logic       e;
    logic [7:0] d;
    int lat, r0, w0, k0, u0;

    rst = 1'b1;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_err_rdata", {bus.err, bus.rdata}, 0);
    chk("rst_strobes", {bus.cache_re, bus.cache_we}, 0);
    chk("rst_addr_wdata", {bus.cache_addr, bus.cache_wdata}, 0);
    rst = 1'b0;

    // read by requester 0
    r0 = re_cnt; w0 = we_cnt;
    bus.req_addr[7:0] = 8'h12; bus.req_we = 2'b00; bus.req = 2'b01;
    wait_ack(40, a, e, d, lat);
    bus.req = 2'b00;
    chk("t1_ack", a, 2'b01);
    chk("t1_err", e, 0);
    chk("t1_rdata", d, 8'hED);
    chk("t1_latency", lat, 4);
    chk("t1_re_pulses", re_cnt - r0, 1);
    chk("t1_we_pulses", we_cnt - w0, 0);
    chk("t1_addr", s_addr, 8'h12);
    @(negedge clk);
    chk("t1_ack_drop", {bus.ack, bus.err, bus.rdata}, 0);

    // write by requester 1, request fields scrambled after grant
    r0 = re_cnt; w0 = we_cnt; u0 = unstable;
    bus.req_addr[15:8] = 8'h34; bus.req_wdata[15:8] = 8'hA5; bus.req_we = 2'b10; bus.req = 2'b10;
    repeat (2) @(negedge clk);
    bus.req_addr[15:8] = 8'hFF; bus.req_wdata[15:8] = 8'h00; bus.req_we = 2'b00;
    wait_ack(40, a, e, d, lat);
    bus.req = 2'b00;
    chk("t3_ack", a, 2'b10);
    chk("t3_err", e, 0);
    chk("t3_rdata", d, 0);
    chk("t3_latency", lat, 2);
    chk("t3_we_pulses", we_cnt - w0, 1);
    chk("t3_re_pulses", re_cnt - r0, 0);
    chk("t3_addr", s_addr, 8'h34);
    chk("t3_wdata", s_wdata, 8'hA5);
    chk("t3_stable", unstable - u0, 0);
    @(negedge clk);

    // both requesting, held across four transactions
    r0 = re_cnt;
    bus.req_we = 2'b00; bus.req_addr = {8'h40, 8'h20}; bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(40, a, e, d, lat);
      if (i == 3) bus.req = 2'b00;
      chk($sformatf("t2_ack%0d", i), a, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_rdata%0d", i), d, (i % 2 == 0) ? 8'hDF : 8'hBF);
      chk($sformatf("t2_latency%0d", i), lat, (i == 0) ? 4 : 5);
    end
    @(negedge clk);
    chk("t2_re_pulses", re_cnt - r0, 4);
    chk("onehot_violations", onehot_bad, 0);
    chk("dual_strobe", both_cnt, 0);

    // cache busy holds off the grant
    force_busy = 1'b1;
    @(negedge clk);
    r0 = re_cnt;
    bus.req_addr[15:8] = 8'h66; bus.req = 2'b10;
    repeat (6) @(negedge clk);
    chk("busy_no_strobe", re_cnt - r0, 0);
    force_busy = 1'b0;
    wait_ack(40, a, e, d, lat);
    bus.req = 2'b00;
    stray_reqs += 2;
    chk("t5_ack", a, 2'b10);
    chk("t5_rdata", d, 8'h99);
    // stray done pulses in RESP/IDLE must not start or finish anything
    @(negedge clk);
    k0 = ack_cnt; r0 = re_cnt;
    repeat (8) @(negedge clk);
    chk("t5_no_spurious_ack", ack_cnt - k0, 0);
    chk("t5_no_strobe", (re_cnt - r0) + (we_cnt - w0 - 1), 0);

    // timeout: cache never answers
    no_done = 1'b1;
    bus.req_addr[7:0] = 8'h55; bus.req = 2'b01;
    wait_ack(60, a, e, d, lat);
    bus.req = 2'b00;
    no_done = 1'b0;
    chk("t4_ack", a, 2'b01);
    chk("t4_err", e, 1);
    chk("t4_rdata", d, 0);
    chk("t4_latency", lat, 18);
    @(negedge clk);
    chk("t4_err_drop", {bus.ack, bus.err}, 0);

    // done in the same cycle the counter reaches TIMEOUT
    done_dly = 16;
    bus.req_addr[7:0] = 8'h0F; bus.req = 2'b01;
    wait_ack(60, a, e, d, lat);
    bus.req = 2'b00;
    done_dly = 6;
    chk("t4b_err", e, 0);
    chk("t4b_rdata", d, 8'hF0);
    chk("t4b_latency", lat, 18);
    @(negedge clk);

    // reset while waiting on requester 1; ptr is 1 beforehand
    bus.req_addr[15:8] = 8'h77; bus.req = 2'b10;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.cache_re) begin
        lat = i;
        break;
      end
    end
    chk("t6_strobe_seen", lat, 1);
    @(negedge clk);
    k0 = ack_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ack_err", {bus.ack, bus.err, bus.rdata}, 0);
    chk("t6_rst_strobes", {bus.cache_re, bus.cache_we}, 0);
    chk("t6_rst_addr", bus.cache_addr, 0);
    rst = 1'b0;
    done_dly = 2;
    bus.req_addr[7:0] = 8'h81; bus.req = 2'b11;
    wait_ack(60, a, e, d, lat);
    bus.req = 2'b00;
    chk("t6_ack_after_rst", a, 2'b01);
    chk("t6_rdata", d, 8'h7E);
    chk("t6_err", e, 0);
    @(negedge clk);
    chk("t6_ack_count", ack_cnt - k0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
